// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter slice: op encodings,
// datapath widths and the request bundle fed to the shifter.
package shift_pkg;

  localparam int SH_DATA_W = 16;
  localparam int SH_CNT_W  = 4;

  typedef enum logic [1:0] {
    SH_ROL = 2'b00,
    SH_SLL = 2'b01,
    SH_ROR = 2'b10,
    SH_SRL = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [SH_DATA_W-1:0] data;
    logic [SH_CNT_W-1:0]  cnt;
    shift_op_e            op;
  } shift_req_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Bus bundle between the two shift requesters, the arbiter and the
// writeback consumer. "master" is the requester/consumer side, "slave" the arbiter.
interface shift_arbiter_if
  import shift_pkg::*;
#(
  parameter int DATA_W = SH_DATA_W,
  parameter int CNT_W  = SH_CNT_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [CNT_W-1:0]  req0_cnt;
  logic [1:0]        req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [CNT_W-1:0]  req1_cnt;
  logic [1:0]        req1_op;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_id;

  modport master (
    output req0_valid, req0_data, req0_cnt, req0_op,
    input  req0_ready,
    output req1_valid, req1_data, req1_cnt, req1_op,
    input  req1_ready,
    input  out_valid, out_data, out_id,
    output out_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_cnt, req0_op,
    output req0_ready,
    input  req1_valid, req1_data, req1_cnt, req1_op,
    output req1_ready,
    output out_valid, out_data, out_id,
    input  out_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter. Round-robin by default; defining SHIFT_ARB_FIXED_PRIO_EN
// makes requester 0 always win and removes the pointer register.
module rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef SHIFT_ARB_FIXED_PRIO_EN

  // Fixed priority: requester 0 dominates
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0];
    grant[1] = req[1] & ~req[0];
  end

`else

  logic ptr_r;

  // Contended grant goes to the requester named by the pointer
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | (ptr_r == 1'b0));
    grant[1] = req[1] & (~req[0] | (ptr_r == 1'b1));
  end

  // Pointer moves to the loser of every accept, even an uncontended one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= RR_INIT;
    end else if (accept) begin
      ptr_r <= grant[0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

`endif

endmodule

// File: rtl/shifter.sv
// 16-bit combinational barrel shifter: rotate/shift left/right by 0..15.
// Rotates use a doubled operand so a count of zero needs no special case.
module shifter
  import shift_pkg::*;
(
  input  logic [SH_DATA_W-1:0] data,
  input  logic [SH_CNT_W-1:0]  cnt,
  input  shift_op_e            op,
  output logic [SH_DATA_W-1:0] result
);

  logic [2*SH_DATA_W-1:0] dbl_s;
  logic [2*SH_DATA_W-1:0] rol_s;
  logic [2*SH_DATA_W-1:0] ror_s;

  // Op decode and shift network
  always_comb begin
    dbl_s  = {data, data};
    rol_s  = dbl_s << cnt;
    ror_s  = dbl_s >> cnt;
    result = data;
    case (op)
      SH_ROL:  result = rol_s[2*SH_DATA_W-1:SH_DATA_W];
      SH_SLL:  result = data << cnt;
      SH_ROR:  result = ror_s[SH_DATA_W-1:0];
      SH_SRL:  result = data >> cnt;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between the ALU and microcode shift paths with a
// one-entry result register. Optional SHIFT_ARB_FIXED_PRIO_EN selects fixed priority.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 4,
  parameter int RR_INIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  shift_arbiter_if.slave bus
);

  if (DATA_W != SH_DATA_W || CNT_W != SH_CNT_W) begin : g_bad_width
    $error("shift_arbiter: DATA_W/CNT_W must be 16/4 to match shifter");
  end
  if (RR_INIT != 0 && RR_INIT != 1) begin : g_bad_rr_init
    $error("shift_arbiter: RR_INIT must be 0 or 1");
  end

  logic              slot_free_s;
  logic              accept_s;
  logic              sel1_s;
  logic [1:0]        grant_s;
  shift_req_t        req0_s;
  shift_req_t        req1_s;
  shift_req_t        sel_req_s;
  logic [DATA_W-1:0] shift_res_s;

  logic              out_valid_r;
  logic              out_id_r;
  logic [DATA_W-1:0] out_data_r;

  rr_arb2 #(
    .RR_INIT (1'(RR_INIT))
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .accept (accept_s),
    .grant  (grant_s)
  );

  // A drain and a new accept may share a cycle
  assign slot_free_s    = ~out_valid_r | bus.out_ready;
  assign bus.req0_ready = grant_s[0] & slot_free_s;
  assign bus.req1_ready = grant_s[1] & slot_free_s;
  assign sel1_s         = bus.req1_valid & bus.req1_ready;
  assign accept_s       = (bus.req0_valid & bus.req0_ready) | sel1_s;

  // Operand mux; idles on requester 0 when nothing is accepted
  always_comb begin
    req0_s = '{data: bus.req0_data, cnt: bus.req0_cnt, op: shift_op_e'(bus.req0_op)};
    req1_s = '{data: bus.req1_data, cnt: bus.req1_cnt, op: shift_op_e'(bus.req1_op)};
    if (sel1_s) begin
      sel_req_s = req1_s;
    end else begin
      sel_req_s = req0_s;
    end
  end

  shifter u_shifter (
    .data   (sel_req_s.data),
    .cnt    (sel_req_s.cnt),
    .op     (sel_req_s.op),
    .result (shift_res_s)
  );

  // One-entry result register with valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_id_r    <= 1'b0;
      out_data_r  <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_id_r    <= sel1_s;
      out_data_r  <= shift_res_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_id    = out_id_r;
  assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed-vector bench for shift_arbiter; expectations are hand-computed.
// Round-robin checks run by default, fixed-priority checks under SHIFT_ARB_FIXED_PRIO_EN.
module tb_shift_arbiter;

  logic clk;
  logic rst_n;
  int   err_cnt;
  int   chk_cnt;

  shift_arbiter_if bus ();

  shift_arbiter #(
    .DATA_W  (16),
    .CNT_W   (4),
    .RR_INIT (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Single-requester transaction; entered and left just after a rising edge
  task automatic issue(input bit id, input logic [15:0] d, input logic [3:0] c,
                       input logic [1:0] op, input logic [15:0] want);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_cnt = c; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_cnt = c; bus.req0_op = op;
    end
    @(negedge clk);
    check("issue_ready0", 32'(bus.req0_ready), 32'(!id));
    check("issue_ready1", 32'(bus.req1_ready), 32'(id));
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("issue_valid", 32'(bus.out_valid), 32'd1);
    check("issue_data",  32'(bus.out_data),  32'(want));
    check("issue_id",    32'(bus.out_id),    32'(id));
    @(posedge clk); #1;
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = 16'h0000; bus.req0_cnt = 4'd0; bus.req0_op = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_data = 16'h0000; bus.req1_cnt = 4'd0; bus.req1_op = 2'b00;
    bus.out_ready  = 1'b1;
    #12;
    check("rst_valid",  32'(bus.out_valid),  32'd0);
    check("rst_data",   32'(bus.out_data),   32'd0);
    check("rst_id",     32'(bus.out_id),     32'd0);
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(1'b0, 16'h8001, 4'd1,  2'b00, 16'h0003);
    issue(1'b1, 16'h8000, 4'd15, 2'b11, 16'h0001);
    issue(1'b1, 16'h00FF, 4'd8,  2'b01, 16'hFF00);
    issue(1'b0, 16'hA5A5, 4'd0,  2'b11, 16'hA5A5);
    issue(1'b1, 16'h1234, 4'd4,  2'b00, 16'h2341);
    @(negedge clk);
    check("idle_drain_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Fresh reset so the pointer starts at RR_INIT
    rst_n = 1'b0;
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 16'h0001; bus.req0_cnt = 4'd4; bus.req0_op = 2'b10;
    bus.req1_valid = 1'b1; bus.req1_data = 16'h0003; bus.req1_cnt = 4'd2; bus.req1_op = 2'b01;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        check("fp_ready0", 32'(bus.req0_ready), 32'd1);
        check("fp_ready1", 32'(bus.req1_ready), 32'd0);
      end
      if (i > 0) begin
        check("fp_id",   32'(bus.out_id),   32'd0);
        check("fp_data", 32'(bus.out_data), 32'h1000);
      end
      @(posedge clk); #1;
    end
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_ready0", 32'(bus.req0_ready), 32'((i % 2) == 0));
      check("rr_ready1", 32'(bus.req1_ready), 32'((i % 2) == 1));
      if (i > 0) begin
        check("rr_valid", 32'(bus.out_valid), 32'd1);
        check("rr_id",    32'(bus.out_id),    32'((i - 1) % 2));
        check("rr_data",  32'(bus.out_data),  ((i - 1) % 2 == 0) ? 32'h1000 : 32'h000C);
      end
      @(posedge clk); #1;
    end

    // Backpressure: last result (req1) must hold, nobody accepted
    bus.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("bp_valid",  32'(bus.out_valid),  32'd1);
      check("bp_id",     32'(bus.out_id),     32'd1);
      check("bp_data",   32'(bus.out_data),   32'h000C);
      check("bp_ready0", 32'(bus.req0_ready), 32'd0);
      check("bp_ready1", 32'(bus.req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("drain_ready0", 32'(bus.req0_ready), 32'd1);
    check("drain_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_id",   32'(bus.out_id),   32'd0);
    check("drain_data", 32'(bus.out_data), 32'h1000);

    // Pointer now favours req1; async reset must clear output and pointer
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data",  32'(bus.out_data),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid",  32'(bus.out_valid),  32'd0);
    check("post_rst_ready0", 32'(bus.req0_ready), 32'd1);
    check("post_rst_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_id",    32'(bus.out_id),    32'd0);
    check("post_rst_out_v", 32'(bus.out_valid), 32'd1);
`endif

    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
